// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
  typedef enum logic {SRC_IF = 1'b0, SRC_D = 1'b1} src_t;
endpackage

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr: saturating count of data grants taken while a fetch waits
// ports: clk, rst; inc (data granted over a pending fetch), clr (fetch granted); at_max (fetch must win next)
module mem_arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  localparam int W = $clog2(STARVE_MAX + 2);
  logic [W-1:0] cnt;
  assign at_max = cnt == W'(STARVE_MAX);
  always_ff @(posedge clk)
    cnt <= rst ? '0 : clr ? '0 : (inc && !at_max) ? cnt + W'(1) : cnt;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and load/store ports
// ports: if_* fetch request/grant/response; d_* data request/grant/response;
//        mem_* memory strobes, address, write data and read data; busy while an access is in flight
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  if (MEM_LAT < 1) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be at least 1");
  end
  localparam int LW = $clog2(MEM_LAT + 1);
  state_t state, state_d;
  src_t src_q;
  logic we_q, at_max, lat_done, idle_ok;
  logic [LW-1:0] lat_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  assign lat_done = lat_cnt == LW'(MEM_LAT);
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  mem_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk(clk), .rst(rst), .inc(d_gnt && if_req), .clr(if_gnt), .at_max(at_max)
  );
  always_ff @(posedge clk)
    state <= rst ? ST_IDLE : state_d;
  // data wins a collision unless the fetch has already been passed over STARVE_MAX times
  always_comb begin
    idle_ok = state == ST_IDLE && !rst;
    d_gnt = idle_ok && d_req && !(if_req && at_max);
    if_gnt = idle_ok && if_req && !(d_req && !at_max);
    busy = state == ST_ACCESS;
    mem_read = busy && !we_q;
    mem_write = busy && we_q;
    state_d = (state == ST_IDLE) ? ((if_gnt || d_gnt) ? ST_ACCESS : ST_IDLE) :
              (state == ST_ACCESS) ? (lat_done ? ST_RESP : ST_ACCESS) : ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q <= SRC_IF;
      we_q <= 1'b0;
      lat_cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      if_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      if_rdata <= '0;
      d_rdata <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      if (if_gnt || d_gnt) begin
        src_q <= d_gnt ? SRC_D : SRC_IF;
        we_q <= d_gnt && d_we;
        addr_q <= d_gnt ? d_addr : if_addr;
        wdata_q <= (d_gnt && d_we) ? d_wdata : '0;
        lat_cnt <= LW'(1);
      end else if (busy && !lat_done)
        lat_cnt <= lat_cnt + LW'(1);
      if (busy && lat_done) begin
        if (src_q == SRC_D) begin
          d_rvalid <= 1'b1;
          d_rdata <= we_q ? '0 : mem_rdata;
        end else begin
          if_rvalid <= 1'b1;
          if_rdata <= mem_rdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=4)
module tb_mem_port_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic if_req = 1'b1, d_req = 1'b1, d_we = 1'b0;
  logic [31:0] if_addr = 32'h0, d_addr = 32'h44, d_wdata = 32'h0;
  logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_read, mem_write, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {logic src; logic [31:0] data; int due;} exp_t;
  exp_t q[$];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  assign mem_rdata = mem_addr + 32'd3;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    #2;
    if (!rst && (if_rvalid || d_rvalid)) begin
      total++;
      if (if_rvalid && d_rvalid) begin
        bad++;
        $display("FAIL rvalid_both: if_rvalid=1 d_rvalid=1 cycle=%0d, required only one", cyc);
      end else if (q.size() == 0) begin
        bad++;
        $display("FAIL rvalid_unexpected: if_rvalid=%0b d_rvalid=%0b cycle=%0d, required none", if_rvalid, d_rvalid, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (d_rvalid !== e.src || (e.src ? d_rdata : if_rdata) !== e.data || cyc != e.due) begin
          bad++;
          $display("FAIL response: src=%0b data=%h cycle=%0d, required src=%0b data=%h cycle=%0d",
                   d_rvalid, e.src ? d_rdata : if_rdata, cyc, e.src, e.data, e.due);
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      total++;
      if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_read, mem_write, busy, if_rdata, d_rdata, mem_addr, mem_wdata} !== '0) begin
        bad++;
        $display("FAIL reset_outputs: gnt=%b%b rv=%b%b rd=%b wr=%b busy=%b addr=%h, required all 0",
                 if_gnt, d_gnt, if_rvalid, d_rvalid, mem_read, mem_write, busy, mem_addr);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({if_gnt, d_gnt} !== 2'b01) begin
      bad++;
      $display("FAIL reset_release_gnt: if_gnt=%b d_gnt=%b, required 0 1", if_gnt, d_gnt);
    end
    q.push_back('{1'b1, 32'h47, cyc + 3});
    @(negedge clk);
    if_req = 1'b0;
    d_req = 1'b0;
    drain();
  endtask

  task automatic test_lone_fetch();
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 32'h10;
    #1;
    total++;
    if ({if_gnt, d_gnt} !== 2'b10) begin
      bad++;
      $display("FAIL fetch_gnt: if_gnt=%b d_gnt=%b, required 1 0", if_gnt, d_gnt);
    end
    q.push_back('{1'b0, 32'h13, cyc + 3});
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      if_req = 1'b0;
      #1;
      total++;
      if ({mem_read, mem_write, busy} !== 3'b101 || mem_addr !== 32'h10 || mem_wdata !== 32'h0) begin
        bad++;
        $display("FAIL fetch_access: rd=%b wr=%b busy=%b addr=%h wdata=%h, required 1 0 1 00000010 00000000",
                 mem_read, mem_write, busy, mem_addr, mem_wdata);
      end
    end
    @(negedge clk);
    #1;
    total++;
    if ({mem_read, mem_write, busy} !== 3'b000) begin
      bad++;
      $display("FAIL fetch_resp_strobes: rd=%b wr=%b busy=%b, required 0 0 0", mem_read, mem_write, busy);
    end
    drain();
  endtask

  task automatic test_collision();
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 32'h40;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h200;
    #1;
    total++;
    if ({if_gnt, d_gnt} !== 2'b01) begin
      bad++;
      $display("FAIL collision_d_gnt: if_gnt=%b d_gnt=%b, required 0 1", if_gnt, d_gnt);
    end
    q.push_back('{1'b1, 32'h203, cyc + 3});
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      d_req = 1'b0;
      #1;
      total++;
      if ({if_gnt, d_gnt} !== ((i == 4) ? 2'b10 : 2'b00)) begin
        bad++;
        $display("FAIL collision_gnt_t%0d: if_gnt=%b d_gnt=%b, required %b", i, if_gnt, d_gnt, (i == 4) ? 2'b10 : 2'b00);
      end
    end
    q.push_back('{1'b0, 32'h43, cyc + 3});
    @(negedge clk);
    if_req = 1'b0;
    drain();
  endtask

  task automatic test_starvation();
    logic [1:0] exp_g;
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 32'h80;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h300;
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      exp_g = (c == 16) ? 2'b10 : (c % 4 == 0) ? 2'b01 : 2'b00;
      total++;
      if ({if_gnt, d_gnt} !== exp_g) begin
        bad++;
        $display("FAIL starve_gnt_t%0d: if_gnt=%b d_gnt=%b, required %b", c, if_gnt, d_gnt, exp_g);
      end
      if (exp_g == 2'b01) q.push_back('{1'b1, 32'h303, cyc + 3});
      if (exp_g == 2'b10) q.push_back('{1'b0, 32'h83, cyc + 3});
    end
    @(negedge clk);
    if_req = 1'b0;
    d_req = 1'b0;
    drain();
  endtask

  task automatic test_store();
    @(negedge clk);
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h100;
    d_wdata = 32'hDEADBEEF;
    #1;
    total++;
    if ({if_gnt, d_gnt} !== 2'b01) begin
      bad++;
      $display("FAIL store_gnt: if_gnt=%b d_gnt=%b, required 0 1", if_gnt, d_gnt);
    end
    q.push_back('{1'b1, 32'h0, cyc + 3});
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      d_req = 1'b0;
      d_we = 1'b0;
      #1;
      total++;
      if ({mem_read, mem_write} !== 2'b01 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) begin
        bad++;
        $display("FAIL store_access: rd=%b wr=%b addr=%h wdata=%h, required 0 1 00000100 deadbeef",
                 mem_read, mem_write, mem_addr, mem_wdata);
      end
    end
    drain();
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 32'h20;
    #1;
    total++;
    if (if_gnt !== 1'b1) begin
      bad++;
      $display("FAIL midop_gnt: if_gnt=%b, required 1", if_gnt);
    end
    @(negedge clk);
    if_req = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if (mem_read !== 1'b1) begin
      bad++;
      $display("FAIL midop_access: mem_read=%b, required 1", mem_read);
    end
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if ({mem_read, mem_write, busy, if_rvalid, d_rvalid} !== 5'b0) begin
        bad++;
        $display("FAIL midop_abort_t%0d: rd=%b wr=%b busy=%b if_rv=%b d_rv=%b, required all 0",
                 i, mem_read, mem_write, busy, if_rvalid, d_rvalid);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_lone_fetch();
    test_collision();
    test_starvation();
    test_store();
    test_reset_mid_op();
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-ported memory between the CPU instruction-fetch port and the data load/store port.
- Sits between the CPU (instr_read/instr_addr/instr_out, data_read/data_write/data_addr/data_in/data_out) and the memory model.
- Serialises accesses, inserts the memory's fixed latency and returns responses to the correct requester.
- Data requests have priority; a starvation guard bounds fetch stalls.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles the memory strobes are held before mem_rdata is valid; minimum 1. MEM_LAT=0 is an elaboration error.
- STARVE_MAX, 4, consecutive data grants allowed while a fetch is pending.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch data valid, one-cycle pulse.
- if_rdata  out  DATA_W  fetch data.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  data completion, one-cycle pulse.
- d_rdata  out  DATA_W  load data; 0 for stores.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  transaction in flight.

Behaviour:
- Reset: while rst is sampled high, all outputs are 0, state is IDLE, starve counter is 0, and the latched source is IF. Reset dominates every other event.
- FSM states:
  - IDLE → ACCESS on any request.
  - ACCESS → RESP after MEM_LAT cycles.
  - RESP → IDLE unconditionally.
- IDLE, acceptance cycle T:
  - if_gnt/d_gnt are combinational and asserted only in IDLE with rst low. Exactly one gnt is asserted per accepted request.
  - The requester may change or drop req from T+1 onward.
  - Address, we, wdata and source are latched at T.
- Winner selection:
  - Only d_req → data wins.
  - Only if_req → fetch wins.
  - Both → data wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
- Starve counter:
  - Increments (saturating at STARVE_MAX) on each data grant while if_req is high.
  - Clears on a fetch grant.
  - Otherwise holds.
- ACCESS, cycles T+1 .. T+MEM_LAT:
  - mem_addr and mem_wdata are registered and stable.
  - Exactly one of mem_read/mem_write is high; mem_write only for d_we=1.
  - mem_wdata is 0 on reads.
  - busy = 1.
- Read capture: mem_rdata is sampled at the clock edge ending cycle T+MEM_LAT.
- RESP, cycle T+MEM_LAT+1:
  - The latched source's rvalid pulses for one cycle with registered rdata; the other rvalid stays 0.
  - Strobes are 0 and busy = 0.
- Back-to-back: the next grant occurs no earlier than T+MEM_LAT+2. Throughput is one access per MEM_LAT+2 cycles.
- rdata outputs hold their last value between pulses and are 0 after reset.
- Stores return d_rvalid with d_rdata = 0.
- Reset mid-transaction:
  - The access is aborted and no rvalid is issued.
  - Strobes are 0 from the edge where rst is sampled.
  - A request held across reset is granted in the first cycle rst is low.
- No address checking; misaligned addresses pass through unchanged.

Decomposition:
- Package mem_arb_pkg: state encoding (ST_IDLE, ST_ACCESS, ST_RESP) and source ids (SRC_IF=0, SRC_D=1).
- One natural sub-module, mem_arb_starve_ctr: saturating counter with inc/clr/at_max, parameterised by STARVE_MAX.
- The FSM and datapath registers stay in the top module.

Test Plan (MEM_LAT=2, STARVE_MAX=4):
- Reset: rst high 3 cycles with if_req=d_req=1 → all outputs 0 throughout. d_gnt=1 in the first cycle after rst falls.
- Lone fetch: if_req, if_addr=0x0000_0010, mem_rdata=0x0000_0013 → if_gnt at T. mem_read=1 with mem_addr=0x10 at T+1 and T+2. if_rvalid=1 with if_rdata=0x13 at T+3 only.
- Collision: if_req=d_req=1 at T, d_we=0, d_addr=0x200 → d_gnt at T. d_rvalid at T+3. if_gnt at T+4, if_rvalid at T+7.
- Starvation: if_req and d_req both held high → data granted at T, T+4, T+8, T+12. Fetch granted at T+16. Data granted at T+20.
- Store: d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF → mem_write=1 with those values at T+1..T+2 and mem_read=0. d_rvalid at T+3 with d_rdata=0.
- Reset mid-op: fetch granted at T, rst high at T+1 → mem_read=0 from T+2. No if_rvalid, busy=0.
